sprite_anim_ctrl: RTL and testbench
===================================

SPRITE_ANIM_CTRL -- requirements
Module: sprite_anim_ctrl

Interface
REQ-001 SHALL have parameter SPR_W, default 64: sprite width in pixels, power of two.
REQ-002 SHALL have parameter SPR_H, default 64: sprite height in pixels.
REQ-003 SHALL have parameter HOLD_FRAMES, default 6: video frames each animation frame is held, range 1..15.
REQ-004 SHALL have port vga_clk, input, 1: sole clock, pixel clock.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port frame_start, input, 1: one-cycle pulse at the start of vertical blank.
REQ-007 SHALL have ports draw_x and draw_y, input, 10 each: current pixel coordinate.
REQ-008 SHALL have ports pos_x and pos_y, input, 10 each: sprite top-left corner on screen.
REQ-009 SHALL have ports act_req, input, 2 (0 STAND, 1 WALK, 2 PUNCH, 3 reserved), and act_valid, input, 1: action request.
REQ-010 SHALL have port act_ack, output, 1: request accepted, one-cycle pulse.
REQ-011 SHALL have port flip, input, 1: mirror the sprite horizontally (see Configuration).
REQ-012 SHALL have ports rom_address, output, 16 (sprite ROM address), and sprite_on, output, 1 (address valid, pixel inside sprite).
REQ-013 SHALL have ports frame_idx, output, 3 (current animation frame) and busy, output, 1 (high while PUNCH is active).

Function
REQ-014 SHALL implement FSM states STAND, WALK, PUNCH; state, frame_idx and hold counter SHALL change only on cycles where frame_start=1.
REQ-015 SHALL latch a valid request as pending when act_valid=1 and busy=0, pulse act_ack the same cycle, and keep only the newest pending request.
REQ-016 SHALL, when busy=1, ignore act_valid and hold act_ack low; act_req=3 SHALL be ignored with no ack.
REQ-017 SHALL, on frame_start with a pending request that differs from the current state, enter the requested state with frame_idx=0 and hold count 0, then clear the pending request; a request equal to the current state SHALL be cleared with no restart.
REQ-018 SHALL otherwise increment the hold counter on frame_start and, when it reaches HOLD_FRAMES-1, clear it and advance frame_idx.
REQ-019 SHALL use frame counts STAND 4 and WALK 6 looping (3->0, 5->0); PUNCH 5 one-shot, whose frame 4 expiry enters STAND at frame 0.
REQ-020 SHALL assert busy combinationally from state==PUNCH.
REQ-021 SHALL compute rel_x=draw_x-pos_x and rel_y=draw_y-pos_y modulo 2^10, with inside defined as rel_x<SPR_W and rel_y<SPR_H.
REQ-022 SHALL register rom_address=BASE[state]+frame_idx*SPR_W*SPR_H+rel_y*SPR_W+col and sprite_on=inside with latency 1 vga_clk, where col=rel_x unflipped.
REQ-023 SHALL set the package defaults BASE STAND=0, WALK=16384 and PUNCH=40960, for a total of 61440 words.
REQ-024 SHALL drive rom_address=0 when inside=0.

Reset
REQ-025 SHALL, on reset, set state STAND, frame_idx 0, hold 0, no pending request, act_ack 0, rom_address 0 and sprite_on 0.
REQ-026 SHALL give reset priority over frame_start and act_valid; reset during PUNCH SHALL return to STAND with busy=0 next cycle.

Configuration
REQ-027 SHALL, with SPRITE_FLIP_EN defined, use col=SPR_W-1-rel_x when flip=1, sampling flip only on frame_start.
REQ-028 SHALL, without SPRITE_FLIP_EN, ignore flip and use col=rel_x always.

Structure
REQ-029 SHALL take the action enum, per-action base addresses and frame counts, and ADDR_W=16 from shared package kof_sprite_pkg.
REQ-030 SHALL place the hold counter and frame_idx advance/wrap logic in one sub-module, anim_frame_timer.

Verification
REQ-031 SHALL verify: reset, then 24 frame_start pulses with HOLD_FRAMES=6 -> frame_idx 0,1,2,3 then 0; busy=0 throughout.
REQ-032 SHALL verify: PUNCH requested -> ack same cycle; next frame_start gives busy=1, frame_idx=0; after 30 frame_starts state STAND, busy=0.
REQ-033 SHALL verify: WALK requested while busy -> no ack, state unchanged after PUNCH completes.
REQ-034 SHALL verify: pos=(100,50), draw=(110,53), WALK frame 2 -> next cycle rom_address=16384+8192+3*64+10=24778 and sprite_on=1; draw_x=164 -> sprite_on=0, rom_address=0.
REQ-035 SHALL verify: with SPRITE_FLIP_EN, flip=1 and rel_x=10 -> col=53; without the macro -> col=10.
REQ-036 SHALL verify: reset asserted mid-PUNCH frame 3 -> next cycle STAND, frame_idx 0, outputs 0.

Source files
------------

// File: rtl/kof_sprite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kof_sprite_pkg
//  Description : Shared sprite definitions. Holds the action enum, the ROM
//                base address of each action's frame strip, the frame count
//                of each action and the ROM address width.
//  Revision    : 1.0  initial release
// ============================================================================
package kof_sprite_pkg;

    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        ACT_STAND = 2'd0,
        ACT_WALK  = 2'd1,
        ACT_PUNCH = 2'd2,
        ACT_RSVD  = 2'd3
    } action_t;

    // ROM layout: STAND 4x4096, WALK 6x4096, PUNCH 5x4096 = 61440 words
    localparam logic [ADDR_W-1:0] C_BASE_STAND = 16'd0;
    localparam logic [ADDR_W-1:0] C_BASE_WALK  = 16'd16384;
    localparam logic [ADDR_W-1:0] C_BASE_PUNCH = 16'd40960;

    localparam logic [2:0] C_FRAMES_STAND = 3'd4;
    localparam logic [2:0] C_FRAMES_WALK  = 3'd6;
    localparam logic [2:0] C_FRAMES_PUNCH = 3'd5;

    function automatic logic [ADDR_W-1:0] action_base(input action_t act);
        case (act)
            ACT_WALK:  action_base = C_BASE_WALK;
            ACT_PUNCH: action_base = C_BASE_PUNCH;
            default:   action_base = C_BASE_STAND;
        endcase
    endfunction

    function automatic logic [2:0] action_frames(input action_t act);
        case (act)
            ACT_WALK:  action_frames = C_FRAMES_WALK;
            ACT_PUNCH: action_frames = C_FRAMES_PUNCH;
            default:   action_frames = C_FRAMES_STAND;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/anim_frame_timer.sv
`default_nettype none
// ============================================================================
//  Module      : anim_frame_timer
//  Description : Holds each animation frame for HOLD_FRAMES video frames and
//                advances/wraps the animation frame index. 'wrap' flags the
//                tick on which the last frame expires.
//  Revision    : 1.0  initial release
// ============================================================================
module anim_frame_timer #(
    parameter int HOLD_FRAMES = 6
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       restart,
    input  logic [2:0] frame_count,
    output logic [2:0] frame_idx,
    output logic       wrap
);

    localparam logic [3:0] C_HOLD_LAST = 4'(HOLD_FRAMES - 1);

    logic [3:0] r_hold;
    logic [2:0] r_frame_idx;
    logic       w_hold_done;
    logic       w_last_frame;

    assign w_hold_done  = (r_hold == C_HOLD_LAST);
    assign w_last_frame = (r_frame_idx == (frame_count - 3'd1));
    assign wrap         = tick && !restart && w_hold_done && w_last_frame;
    assign frame_idx    = r_frame_idx;

    // Hold counter and frame index move only on the video-frame tick
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_hold      <= 4'd0;
            r_frame_idx <= 3'd0;
        end else if (tick) begin
            if (restart) begin
                r_hold      <= 4'd0;
                r_frame_idx <= 3'd0;
            end else if (w_hold_done) begin
                r_hold      <= 4'd0;
                r_frame_idx <= w_last_frame ? 3'd0 : r_frame_idx + 3'd1;
            end else begin
                r_hold <= r_hold + 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sprite_anim_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_anim_ctrl
//  Description : Sprite animation controller. Action FSM (STAND/WALK/PUNCH)
//                stepped at frame_start, request handshake, and a registered
//                sprite ROM address generator.
//                Optional feature macro SPRITE_FLIP_EN: horizontal mirroring
//                driven by 'flip', sampled at frame_start.
//  Revision    : 1.0  initial release
// ============================================================================
module sprite_anim_ctrl
    import kof_sprite_pkg::*;
#(
    parameter int SPR_W       = 64,
    parameter int SPR_H       = 64,
    parameter int HOLD_FRAMES = 6
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic [1:0]        act_req,
    input  logic              act_valid,
    output logic              act_ack,
    input  logic              flip,
    output logic [ADDR_W-1:0] rom_address,
    output logic              sprite_on,
    output logic [2:0]        frame_idx,
    output logic              busy
);

    action_t     r_state;
    action_t     r_pend_act;
    logic        r_pend_valid;
    logic        w_restart;
    logic        w_wrap;
    logic        w_accept;

    // A request is taken whenever we are not mid-punch and it is not reserved
    assign busy     = (r_state == ACT_PUNCH);
    assign w_accept = act_valid && !busy && (act_req != ACT_RSVD) && !reset;
    assign act_ack  = w_accept;

    // Switching action restarts the animation from frame 0
    assign w_restart = r_pend_valid && (r_pend_act != r_state);

    anim_frame_timer #(
        .HOLD_FRAMES (HOLD_FRAMES)
    ) u_timer (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .tick        (frame_start),
        .restart     (w_restart),
        .frame_count (action_frames(r_state)),
        .frame_idx   (frame_idx),
        .wrap        (w_wrap)
    );

    // Action FSM and pending-request register; a new accept overrides the clear
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_state      <= ACT_STAND;
            r_pend_act   <= ACT_STAND;
            r_pend_valid <= 1'b0;
        end else begin
            if (frame_start) begin
                r_pend_valid <= 1'b0;
                if (w_restart) begin
                    r_state <= r_pend_act;
                end else if (w_wrap && (r_state == ACT_PUNCH)) begin
                    r_state <= ACT_STAND;
                end
            end
            if (w_accept) begin
                r_pend_act   <= action_t'(act_req);
                r_pend_valid <= 1'b1;
            end
        end
    end

    // ---------------- address generation ----------------
    logic [9:0]  w_rel_x;
    logic [9:0]  w_rel_y;
    logic        w_inside;
    logic        w_mirror;
    logic [31:0] w_col;
    logic [31:0] w_addr_full;
    logic [15:0] w_unused_addr_hi;

    assign w_rel_x  = draw_x - pos_x;
    assign w_rel_y  = draw_y - pos_y;
    assign w_inside = (32'(w_rel_x) < 32'(SPR_W)) && (32'(w_rel_y) < 32'(SPR_H));

`ifdef SPRITE_FLIP_EN
    logic r_flip;

    // Mirror setting only changes between video frames to avoid tearing
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_flip <= 1'b0;
        end else if (frame_start) begin
            r_flip <= flip;
        end
    end

    assign w_mirror = r_flip;
`else
    logic w_unused_flip;
    assign w_unused_flip = flip;
    assign w_mirror      = 1'b0;
`endif

    assign w_col = w_mirror ? (32'(SPR_W - 1) - 32'(w_rel_x)) : 32'(w_rel_x);

    assign w_addr_full = 32'(action_base(r_state))
                       + 32'(frame_idx) * 32'(SPR_W * SPR_H)
                       + 32'(w_rel_y) * 32'(SPR_W)
                       + w_col;
    assign w_unused_addr_hi = w_addr_full[31:16];

    // One-cycle registered ROM address; zero whenever outside the sprite
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            rom_address <= '0;
            sprite_on   <= 1'b0;
        end else begin
            sprite_on   <= w_inside;
            rom_address <= w_inside ? w_addr_full[ADDR_W-1:0] : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_anim_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_anim_ctrl
//  Description : Self-checking bench for sprite_anim_ctrl (default params).
//                Build with or without SPRITE_FLIP_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sprite_anim_ctrl;

    logic        vga_clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic [9:0]  draw_x = '0;
    logic [9:0]  draw_y = '0;
    logic [9:0]  pos_x = 10'd100;
    logic [9:0]  pos_y = 10'd50;
    logic [1:0]  act_req = '0;
    logic        act_valid = 1'b0;
    logic        act_ack;
    logic        flip = 1'b0;
    logic [15:0] rom_address;
    logic        sprite_on;
    logic [2:0]  frame_idx;
    logic        busy;

    int checks = 0;
    int errors = 0;

    sprite_anim_ctrl dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .frame_start (frame_start),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .act_req     (act_req),
        .act_valid   (act_valid),
        .act_ack     (act_ack),
        .flip        (flip),
        .rom_address (rom_address),
        .sprite_on   (sprite_on),
        .frame_idx   (frame_idx),
        .busy        (busy)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        logic [9:0]  dx;
        logic [9:0]  dy;
        logic        exp_on;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic pulse_fs(input int n);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1;
            step();
        end
        frame_start = 1'b0;
    endtask

    task automatic request(input logic [1:0] a, input int exp_ack, input string name);
        act_req   = a;
        act_valid = 1'b1;
        #1;
        chk(name, int'(act_ack), exp_ack);
        step();
        act_valid = 1'b0;
    endtask

    initial begin
        // STAND frame 0, pos (100,50)
        tbl[0] = '{10'd100, 10'd50,  1'b1, 16'd0};
        tbl[1] = '{10'd110, 10'd53,  1'b1, 16'd202};
        tbl[2] = '{10'd163, 10'd113, 1'b1, 16'd4095};
        tbl[3] = '{10'd164, 10'd53,  1'b0, 16'd0};
        tbl[4] = '{10'd110, 10'd114, 1'b0, 16'd0};
        tbl[5] = '{10'd99,  10'd50,  1'b0, 16'd0};
        tbl[6] = '{10'd1023,10'd1023,1'b0, 16'd0};

        // Reset state
        draw_x = 10'd110;
        draw_y = 10'd53;
        step();
        step();
        #1;
        chk("rst_ack", int'(act_ack), 0);
        chk("rst_frame_idx", int'(frame_idx), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sprite_on", int'(sprite_on), 0);
        chk("rst_rom_address", int'(rom_address), 0);
        reset = 1'b0;
        draw_x = 10'd0;
        draw_y = 10'd0;

        // STAND loop: frame advances every 6 frame_starts, wraps 3 -> 0
        for (int k = 1; k <= 24; k++) begin
            pulse_fs(1);
            chk($sformatf("stand_idx_%0d", k), int'(frame_idx), (k / 6) % 4);
            chk($sformatf("stand_busy_%0d", k), int'(busy), 0);
        end

        // Address table in STAND frame 0
        for (int i = 0; i < 7; i++) begin
            draw_x = tbl[i].dx;
            draw_y = tbl[i].dy;
            step();
            chk($sformatf("tbl_on_%0d", i), int'(sprite_on), int'(tbl[i].exp_on));
            chk($sformatf("tbl_addr_%0d", i), int'(rom_address), int'(tbl[i].exp_addr));
        end

        // Flip: rel_x = 10, latched only at frame_start
        draw_x = 10'd110;
        draw_y = 10'd50;
        flip = 1'b1;
        pulse_fs(1);
        flip = 1'b0;
        step();
`ifdef SPRITE_FLIP_EN
        chk("flip_col", int'(rom_address), 53);
`else
        chk("flip_col", int'(rom_address), 10);
`endif
        pulse_fs(1);
        step();
        chk("unflip_col", int'(rom_address), 10);

        // WALK request and frame 2 address
        request(2'd1, 1, "walk_ack");
        pulse_fs(1);
        chk("walk_enter_idx", int'(frame_idx), 0);
        pulse_fs(12);
        chk("walk_idx2", int'(frame_idx), 2);
        draw_x = 10'd110;
        draw_y = 10'd53;
        step();
        chk("walk_addr", int'(rom_address), 24778);
        chk("walk_on", int'(sprite_on), 1);
        draw_x = 10'd164;
        step();
        chk("walk_off_on", int'(sprite_on), 0);
        chk("walk_off_addr", int'(rom_address), 0);
        pulse_fs(18);
        chk("walk_idx5", int'(frame_idx), 5);
        pulse_fs(6);
        chk("walk_wrap", int'(frame_idx), 0);

        // Reserved action: no ack, stays in WALK
        request(2'd3, 0, "rsvd_ack");
        pulse_fs(1);
        draw_x = 10'd100;
        draw_y = 10'd50;
        step();
        chk("rsvd_walk_base", int'(rom_address), 16384);

        // Same-state request: acked, no restart (hold 2 -> 3 more then advance)
        request(2'd1, 1, "same_ack");
        pulse_fs(1);
        pulse_fs(4);
        chk("same_no_restart", int'(frame_idx), 1);

        // PUNCH one-shot, WALK ignored while busy
        request(2'd2, 1, "punch_ack");
        chk("punch_pre_busy", int'(busy), 0);
        pulse_fs(1);
        chk("punch_busy", int'(busy), 1);
        chk("punch_idx0", int'(frame_idx), 0);
        act_req = 2'd1;
        act_valid = 1'b1;
        #1;
        chk("busy_no_ack", int'(act_ack), 0);
        step();
        step();
        act_valid = 1'b0;
        pulse_fs(24);
        chk("punch_idx4", int'(frame_idx), 4);
        pulse_fs(5);
        chk("punch_last_busy", int'(busy), 1);
        pulse_fs(1);
        chk("punch_done_busy", int'(busy), 0);
        chk("punch_done_idx", int'(frame_idx), 0);
        draw_x = 10'd110;
        draw_y = 10'd53;
        step();
        chk("post_punch_stand", int'(rom_address), 202);
        pulse_fs(1);
        step();
        chk("busy_req_dropped", int'(rom_address), 202);

        // Reset mid-PUNCH frame 3 with competing frame_start/act_valid
        request(2'd2, 1, "punch2_ack");
        pulse_fs(1);
        pulse_fs(18);
        chk("punch2_idx3", int'(frame_idx), 3);
        chk("punch2_busy", int'(busy), 1);
        reset = 1'b1;
        frame_start = 1'b1;
        act_req = 2'd1;
        act_valid = 1'b1;
        #1;
        chk("rst_pri_ack", int'(act_ack), 0);
        step();
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_idx", int'(frame_idx), 0);
        chk("rst_mid_addr", int'(rom_address), 0);
        chk("rst_mid_on", int'(sprite_on), 0);
        reset = 1'b0;
        frame_start = 1'b0;
        act_valid = 1'b0;
        step();
        chk("after_rst_stand", int'(rom_address), 202);
        chk("after_rst_on", int'(sprite_on), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
